// File: rtl/prg_loader.sv
// PRG-style ioctl loader and full-RAM zero-clear driving main RAM's clk_sys write port.
// Optional macro PRG_AUTORUN_EN adds an AUTORUN state that types RUN<CR> into the keyboard buffer.
module prg_loader #(
  parameter int             AW        = 16,
  parameter logic [7:0]     PRG_INDEX = 8'd1,
  parameter int             NPTR      = 4,
  parameter logic [NPTR*AW-1:0] PTR_LIST = {16'h00AE, 16'h0031, 16'h002F, 16'h002D}
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          clear_req,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic [AW-1:0] dl_addr,
  output logic [7:0]    dl_data,
  output logic          dl_wr,
  output logic          busy,
  output logic [AW-1:0] end_addr,
  output logic          load_done
);

  localparam int PW = $clog2(2 * NPTR + 1);
  localparam logic [PW-1:0] PATCH_N = PW'(2 * NPTR);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PATCH = 3'd2,
    CLEAR = 3'd3
`ifdef PRG_AUTORUN_EN
    , AUTORUN = 3'd4
`endif
  } state_t;

  state_t state, state_nx;

  logic          dl_prev;
  logic          dl_rise;
  logic          dl_fall;
  logic [AW-1:0] load_addr;
  logic [AW-1:0] clr_ptr;
  logic          payload_seen;
  logic [PW-1:0] patch_idx;
  logic [PW-2:0] ptr_sel;
  logic [AW-1:0] ptr_base;
  logic [AW-1:0] patch_addr;
  logic [7:0]    patch_data;
  logic [15:0]   load16;
  logic [15:0]   end16;
  logic          patch_end;
  logic          clr_end;

  logic          wr_nx;
  logic [AW-1:0] addr_nx;
  logic [7:0]    data_nx;
  logic          done_nx;

  assign dl_rise = ioctl_download & ~dl_prev;
  assign dl_fall = ~ioctl_download & dl_prev;

  // Header bytes and pointer values are 16-bit quantities regardless of AW.
  assign load16 = 16'(load_addr);
  assign end16  = 16'(end_addr);

  // Each pointer entry takes two write slots: low byte at the entry, high byte at entry+1.
  assign ptr_sel    = patch_idx[PW-1:1];
  assign ptr_base   = PTR_LIST[int'(ptr_sel) * AW +: AW];
  assign patch_addr = ptr_base + {{(AW-1){1'b0}}, patch_idx[0]};
  assign patch_data = patch_idx[0] ? end16[15:8] : end16[7:0];

  // A phase ends on the gap cycle that follows its final write.
  assign patch_end = dl_wr && (patch_idx == PATCH_N);
  assign clr_end   = dl_wr && (dl_addr == {AW{1'b1}});

`ifdef PRG_AUTORUN_EN
  logic [2:0]    auto_idx;
  logic [AW-1:0] auto_addr;
  logic [7:0]    auto_data;
  logic          auto_end;

  assign auto_end = dl_wr && (auto_idx == 3'd5);

  always_comb begin
    auto_addr = AW'(16'h00EF);
    auto_data = 8'h04;
    case (auto_idx)
      3'd0: begin auto_addr = AW'(16'h0527); auto_data = 8'h52; end
      3'd1: begin auto_addr = AW'(16'h0528); auto_data = 8'h55; end
      3'd2: begin auto_addr = AW'(16'h0529); auto_data = 8'h4E; end
      3'd3: begin auto_addr = AW'(16'h052A); auto_data = 8'h0D; end
      default: ;
    endcase
  end
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clear_req) begin
      state_nx = CLEAR;
    end else begin
      case (state)
        IDLE:  if (dl_rise && (ioctl_index == PRG_INDEX)) state_nx = LOAD;
        LOAD:  if (dl_fall) state_nx = payload_seen ? PATCH : IDLE;
`ifdef PRG_AUTORUN_EN
        PATCH: if (patch_end) state_nx = AUTORUN;
        AUTORUN: if (auto_end) state_nx = IDLE;
`else
        PATCH: if (patch_end) state_nx = IDLE;
`endif
        CLEAR: if (clr_end) state_nx = IDLE;
        default: state_nx = CLEAR;
      endcase
    end
  end

  // Writes are only issued when the previous cycle was not a write, giving the 2-cycle slot.
  always_comb begin
    wr_nx   = 1'b0;
    addr_nx = dl_addr;
    data_nx = dl_data;
    done_nx = 1'b0;
    if (!clear_req) begin
      case (state)
        LOAD: begin
          if (ioctl_wr && (ioctl_addr > 25'd1)) begin
            wr_nx   = 1'b1;
            addr_nx = load_addr;
            data_nx = ioctl_dout;
          end
        end
        PATCH: begin
          if (!dl_wr && (patch_idx != PATCH_N)) begin
            wr_nx   = 1'b1;
            addr_nx = patch_addr;
            data_nx = patch_data;
          end
`ifndef PRG_AUTORUN_EN
          if (patch_end) done_nx = 1'b1;
`endif
        end
`ifdef PRG_AUTORUN_EN
        AUTORUN: begin
          if (!dl_wr && (auto_idx != 3'd5)) begin
            wr_nx   = 1'b1;
            addr_nx = auto_addr;
            data_nx = auto_data;
          end
          if (auto_end) done_nx = 1'b1;
        end
`endif
        CLEAR: begin
          if (!dl_wr) begin
            wr_nx   = 1'b1;
            addr_nx = clr_ptr;
            data_nx = 8'h00;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_addr      <= '0;
      dl_data      <= '0;
      dl_wr        <= 1'b0;
      end_addr     <= '0;
      load_done    <= 1'b0;
      busy         <= 1'b1;
      clr_ptr      <= '0;
      load_addr    <= '0;
      payload_seen <= 1'b0;
      patch_idx    <= '0;
      dl_prev      <= 1'b0;
`ifdef PRG_AUTORUN_EN
      auto_idx     <= '0;
`endif
    end else begin
      dl_prev   <= ioctl_download;
      dl_wr     <= wr_nx;
      dl_addr   <= addr_nx;
      dl_data   <= data_nx;
      load_done <= done_nx;
      if (clear_req) begin
        clr_ptr <= '0;
        busy    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (state_nx == LOAD) begin
              load_addr    <= '0;
              payload_seen <= 1'b0;
            end
          end
          LOAD: begin
            if (ioctl_wr) begin
              if (ioctl_addr == 25'd0)
                load_addr <= AW'({load16[15:8], ioctl_dout});
              else if (ioctl_addr == 25'd1)
                load_addr <= AW'({ioctl_dout, load16[7:0]});
              else begin
                load_addr    <= load_addr + AW'(1);
                payload_seen <= 1'b1;
              end
            end
            if (state_nx == PATCH) begin
              end_addr  <= load_addr;
              patch_idx <= '0;
            end
          end
          PATCH: begin
            if (wr_nx) patch_idx <= patch_idx + PW'(1);
`ifdef PRG_AUTORUN_EN
            auto_idx <= '0;
`endif
          end
`ifdef PRG_AUTORUN_EN
          AUTORUN: begin
            if (wr_nx) auto_idx <= auto_idx + 3'd1;
          end
`endif
          CLEAR: begin
            if (wr_nx) clr_ptr <= clr_ptr + AW'(1);
            if (state_nx == IDLE) busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/prg_loader.md
Name: prg_loader

Overview:
- Generalised program/memory loader for the clk_sys side of main RAM's write port.
- Parses a PRG-style ioctl download: a 2-byte little-endian load address followed by payload.
- Writes the payload sequentially and then patches a parameterised list of 16-bit end-of-program pointers.
- Also performs full-RAM zero-clear on request and after reset. Replaces the hardwired loader/clear logic, which was fixed to 16-bit RAM, 4 pointers and one download index.

Parameters:
- AW, 16, RAM address width; load/end address registers are AW bits.
- PRG_INDEX, 1, ioctl_index value that selects PRG parsing.
- NPTR, 4, number of pointer pairs patched after a load (1..16).
- PTR_LIST, {16'h00AE,16'h0031,16'h002F,16'h002D}, NPTR packed AW-bit low-byte addresses; entry 0 in LSBs; high byte goes to entry+1.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clear_req  in  1  synchronous one-cycle request to zero RAM
- ioctl_download  in  1  download active
- ioctl_index  in  8  download type
- ioctl_wr  in  1  byte strobe; pulses at least 2 cycles apart
- ioctl_addr  in  25  byte offset in file
- ioctl_dout  in  8  byte data
- dl_addr  out  AW  RAM write address
- dl_data  out  8  RAM write data
- dl_wr  out  1  RAM write strobe, one cycle per byte
- busy  out  1  high during CLEAR (use as CPU hold-in-reset)
- end_addr  out  AW  address following last payload byte
- load_done  out  1  one-cycle pulse when patching completes

Behaviour:
- Async reset: dl_addr=0, dl_data=0, dl_wr=0, end_addr=0, load_done=0, busy=1, state=CLEAR with clear pointer=0. Clearing starts on the first clk_sys edge after reset deasserts.
- dl_wr is never high on two consecutive cycles. Every write uses a 2-cycle slot: the write cycle, then a gap cycle.
- States:
  - IDLE
  - LOAD
  - PATCH
  - CLEAR
  - AUTORUN (only with the optional feature)
- IDLE->LOAD: ioctl_download=1 and ioctl_index==PRG_INDEX.
- Downloads with other indices are ignored; the block stays in IDLE.
- LOAD, on each ioctl_wr:
  - ioctl_addr==0: load address [7:0] <= ioctl_dout.
  - ioctl_addr==1: load address [15:8] <= ioctl_dout.
  - Otherwise: next cycle dl_addr=addr, dl_data=ioctl_dout, dl_wr=1; addr increments.
- Latency from ioctl_wr to dl_wr is exactly 1 cycle.
- addr wraps modulo 2^AW (0xFFFF -> 0x0000 for AW=16). Bits above 15 of the header address are zero when AW>16.
- LOAD->PATCH: falling edge of ioctl_download with at least one payload byte written; end_addr latches addr.
- LOAD->IDLE: falling edge with no payload; no patch, no load_done.
- PATCH: for i=0..NPTR-1, write end_addr[7:0] to PTR_LIST[i], then end_addr[15:8] to PTR_LIST[i]+1. That is 2*NPTR writes at one per 2 cycles.
- load_done pulses the cycle after the final patch write; the state then goes to IDLE (or AUTORUN).
- CLEAR:
  - Writes 0x00 to every address 0..2^AW-1 in ascending order, one per slot.
  - busy falls the cycle after the write to the all-ones address; state goes to IDLE.
  - Duration is exactly 2*2^AW cycles from entry.
- clear_req in any state: aborts LOAD/PATCH/AUTORUN immediately, with no partial patch and no load_done. Pointer resets to 0 and busy=1. clear_req during CLEAR restarts from 0.
- Download starting during CLEAR: bytes are dropped. A new download rising edge after CLEAR ends is handled normally.
- ioctl_download falling while PATCH or AUTORUN is active cannot occur twice; a new download rising edge during PATCH is ignored until IDLE.

Optional Feature:
- Macro: PRG_AUTORUN_EN.
- Defined:
  - After PATCH, state AUTORUN writes 'R'(0x52), 'U'(0x55), 'N'(0x4E), 0x0D to keyboard buffer 0x0527..0x052A.
  - It then writes 0x04 to buffer count 0x00EF, using 5 write slots.
  - load_done pulses after the count write instead of after PATCH.
- Undefined: the AUTORUN state and its logic are absent; load_done follows PATCH.

Test Plan:
- Reset release -> busy=1, 65536 writes of 0x00 at addresses 0..0xFFFF, dl_wr never back-to-back; busy=0 at cycle 131072.
- PRG bytes 01 10 AA BB CC (index 1) -> writes AA@0x1001, BB@0x1002, CC@0x1003; end_addr=0x1004; patches 04/10 at 2D/2E, 2F/30, 31/32, AE/AF; single load_done.
- Header FF FF then 3 bytes -> writes at 0xFFFF, 0x0000, 0x0001; end_addr=0x0002.
- Download of index 2 or header-only PRG -> no dl_wr after header, no load_done, end_addr unchanged.
- clear_req mid-PATCH (after 3 patch writes) -> no further pointer writes, load_done stays 0, full clear runs, busy drops after address 0xFFFF.
- With PRG_AUTORUN_EN, load of 01 10 AA -> after patches, writes 52,55,4E,0D at 0x0527..0x052A and 04 at 0x00EF; load_done after the last write.
